// File: rtl/snake_move_ctrl.sv
// Snake move controller: synchronised, debounced direction keys become one-hot
// move pulses issued once per game tick; the tick shortens on each score event.
module snake_move_ctrl #(
    parameter int TICK_DIV  = 25_000_000,
    parameter int TICK_MIN  = 5_000_000,
    parameter int TICK_STEP = 1_000_000,
    parameter int DEBOUNCE  = 500_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_key_l,
    input  logic       i_key_r,
    input  logic       i_key_u,
    input  logic       i_key_d,
    input  logic       i_gameover,
    input  logic       i_hit_score,
    output logic       o_l,
    output logic       o_r,
    output logic       o_u,
    output logic       o_d,
    output logic [1:0] o_dir,
    output logic       o_running
);
    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [PW-1:0] P_DIV = PW'(TICK_DIV);
    localparam logic [PW-1:0] P_ONE = PW'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t        r_state, w_state_nx;
    logic [PW-1:0] r_cnt, w_cnt_nx;
    logic [PW-1:0] r_period, w_period_nx;
    logic [PW-1:0] r_req;
    logic [1:0]    r_dir, w_dir_nx;
    logic [1:0]    r_pend, w_pend_nx;
    logic          r_pend_v, w_pend_v_nx;
    logic [3:0]    r_pulse, w_pulse_nx;
    logic [3:0]    r_sync1, r_sync2, r_stable_q;
    logic [3:0]    w_keys, w_stable, w_press;
    logic          r_hit_q, w_hit_rise;
    logic          w_pv, w_tick;
    logic [1:0]    w_pdir;
    logic [31:0]   w_req32, w_req_sat;

    // Bit index matches the dir encoding: 0=L 1=R 2=U 3=D
    assign w_keys = {i_key_d, i_key_u, i_key_r, i_key_l};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable_q <= '0;
            r_hit_q    <= 1'b0;
        end else begin
            r_sync1    <= w_keys;
            r_sync2    <= r_sync1;
            r_stable_q <= w_stable;
            r_hit_q    <= i_hit_score;
        end
    end

    // A differing synced level must persist DEBOUNCE cycles to flip the stable level
    for (genvar k = 0; k < 4; k++) begin : g_deb
        logic [DW-1:0] r_dcnt;
        logic          r_st;
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_dcnt <= '0;
                r_st   <= 1'b0;
            end else if (r_sync2[k] != r_st) begin
                if (r_dcnt == DW'(DEBOUNCE - 1)) begin
                    r_st   <= r_sync2[k];
                    r_dcnt <= '0;
                end else begin
                    r_dcnt <= r_dcnt + DW'(1);
                end
            end else begin
                r_dcnt <= '0;
            end
        end
        assign w_stable[k] = r_st;
    end

    assign w_press    = w_stable & ~r_stable_q;
    assign w_hit_rise = i_hit_score & ~r_hit_q;

    always_comb begin
        w_pv   = 1'b1;
        w_pdir = 2'd0;
        if      (w_press[0]) w_pdir = 2'd0;
        else if (w_press[1]) w_pdir = 2'd1;
        else if (w_press[2]) w_pdir = 2'd2;
        else if (w_press[3]) w_pdir = 2'd3;
        else                 w_pv   = 1'b0;
    end

    // Saturating period decrement, computed wide so TICK_MIN+TICK_STEP cannot wrap
    assign w_req32   = 32'(r_req);
    assign w_req_sat = (w_req32 >= 32'(TICK_MIN + TICK_STEP)) ? w_req32 - 32'(TICK_STEP)
                                                              : 32'(TICK_MIN);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_period <= P_DIV;
            r_req    <= P_DIV;
            r_dir    <= 2'd0;
            r_pend   <= 2'd0;
            r_pend_v <= 1'b0;
            r_pulse  <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_period <= w_period_nx;
            r_dir    <= w_dir_nx;
            r_pend   <= w_pend_nx;
            r_pend_v <= w_pend_v_nx;
            r_pulse  <= w_pulse_nx;
            if (w_hit_rise) r_req <= PW'(w_req_sat);
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_period_nx = r_period;
        w_dir_nx    = r_dir;
        w_pend_nx   = r_pend;
        w_pend_v_nx = r_pend_v;
        w_pulse_nx  = '0;
        w_tick      = (r_cnt == r_period - P_ONE);
        case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                if (w_pv) begin
                    w_state_nx = S_RUN;
                    w_dir_nx   = w_pdir;
                end
            end
            S_RUN: begin
                if (i_gameover) begin
                    w_state_nx = S_HALT;
                end else begin
                    if (w_tick) begin
                        w_cnt_nx    = '0;
                        w_period_nx = r_req;
                        if (r_pend_v) begin
                            w_dir_nx    = r_pend;
                            w_pend_v_nx = 1'b0;
                        end
                        w_pulse_nx[w_dir_nx] = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt + P_ONE;
                    end
                    // XOR with 1 maps each heading to its opposite (L<->R, U<->D)
                    if (w_pv && (w_pdir != (r_dir ^ 2'b01))) begin
                        w_pend_v_nx = 1'b1;
                        w_pend_nx   = w_pdir;
                    end
                end
            end
            default: ;
        endcase
    end

    assign o_l       = r_pulse[0];
    assign o_r       = r_pulse[1];
    assign o_u       = r_pulse[2];
    assign o_d       = r_pulse[3];
    assign o_dir     = r_dir;
    assign o_running = (r_state == S_RUN);
endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed bench for snake_move_ctrl with a short tick (8) and debounce (2).
module tb_snake_move_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] keys = '0;
    logic       gameover = 1'b0;
    logic       hit = 1'b0;
    logic       l, r, u, d, running;
    logic [1:0] dir;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    localparam logic [3:0] K_L = 4'b0001, K_R = 4'b0010, K_U = 4'b0100, K_D = 4'b1000;

    snake_move_ctrl #(.TICK_DIV(8), .TICK_MIN(4), .TICK_STEP(2), .DEBOUNCE(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_key_l(keys[0]), .i_key_r(keys[1]), .i_key_u(keys[2]), .i_key_d(keys[3]),
        .i_gameover(gameover), .i_hit_score(hit),
        .o_l(l), .o_r(r), .o_u(u), .o_d(d), .o_dir(dir), .o_running(running)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        keys = '0; gameover = 1'b0; hit = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic press(input logic [3:0] k, input int n);
        keys = k;
        repeat (n) @(negedge clk);
        keys = '0;
    endtask

    task automatic wait_run(input string tag, output int at);
        logic found = 1'b0;
        at = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (running) begin found = 1'b1; at = cyc; end
        end
        chk({tag, "_run_seen"}, 32'(found), 1);
    endtask

    task automatic wait_pulse(input string tag, output int at, output logic [3:0] p);
        logic found = 1'b0;
        at = 0;
        p = '0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if ({d, u, r, l} != 4'b0) begin found = 1'b1; at = cyc; p = {d, u, r, l}; end
        end
        chk({tag, "_pulse_seen"}, 32'(found), 1);
        if (found) chk({tag, "_onehot"}, 32'($countones(p)), 1);
    endtask

    int         t_run, t0, t1, n_pulses;
    logic [3:0] p;

    initial begin
        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_pulses", 32'({d, u, r, l}), 0);
        chk("rst_dir", 32'(dir), 0);
        chk("rst_running", 32'(running), 0);

        // U and D together in IDLE: U wins; first pulse one period after entry
        press(K_U | K_D, 3);
        wait_run("ud", t_run);
        chk("ud_dir", 32'(dir), 2);
        wait_pulse("ud1", t0, p);
        chk("ud1_which", 32'(p), 32'(K_U));
        chk("ud1_latency", 32'(t0 - t_run), 8);
        wait_pulse("ud2", t1, p);
        chk("ud2_gap", 32'(t1 - t0), 8);

        // Asynchronous reset mid-RUN clears outputs without a clock edge
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_running", 32'(running), 0);
        chk("arst_dir", 32'(dir), 0);
        chk("arst_pulses", 32'({d, u, r, l}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        press(K_U, 3);
        wait_run("u", t_run);
        wait_pulse("u1", t0, p);
        chk("u1_which", 32'(p), 32'(K_U));
        chk("u1_latency", 32'(t0 - t_run), 8);
        wait_pulse("u2", t1, p);
        chk("u2_gap", 32'(t1 - t0), 8);

        // Reversal is discarded; a perpendicular press takes effect next tick
        do_reset();
        press(K_L, 3);
        wait_run("l", t_run);
        wait_pulse("l1", t0, p);
        press(K_R, 3);
        wait_pulse("rev", t1, p);
        chk("rev_which", 32'(p), 32'(K_L));
        chk("rev_dir", 32'(dir), 0);
        press(K_U, 3);
        wait_pulse("turn", t1, p);
        chk("turn_which", 32'(p), 32'(K_U));
        chk("turn_dir", 32'(dir), 2);

        // 1-cycle bounces are rejected; a held key is accepted
        do_reset();
        for (int i = 0; i < 4; i++) begin
            keys = K_L;
            @(negedge clk);
            keys = '0;
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
        chk("bounce_running", 32'(running), 0);
        press(K_L, 3);
        wait_run("hold", t_run);
        chk("hold_dir", 32'(dir), 0);

        // Score edges shorten the period from the following wrap: 8,6,4,4
        do_reset();
        press(K_R, 3);
        wait_run("spd", t_run);
        wait_pulse("spd0", t0, p);
        hit = 1'b1; repeat (2) @(negedge clk); hit = 1'b0;
        wait_pulse("spd1", t1, p);
        chk("gap_a", 32'(t1 - t0), 8);
        t0 = t1;
        hit = 1'b1; repeat (2) @(negedge clk); hit = 1'b0;
        wait_pulse("spd2", t1, p);
        chk("gap_b", 32'(t1 - t0), 6);
        t0 = t1;
        hit = 1'b1; repeat (2) @(negedge clk); hit = 1'b0;
        wait_pulse("spd3", t1, p);
        chk("gap_c", 32'(t1 - t0), 4);
        t0 = t1;
        wait_pulse("spd4", t1, p);
        chk("gap_d", 32'(t1 - t0), 4);
        chk("spd_which", 32'(p), 32'(K_R));

        // Gameover coinciding with a tick suppresses the pulse and halts
        do_reset();
        press(K_D, 3);
        wait_run("go", t_run);
        wait_pulse("go1", t0, p);
        repeat (7) @(negedge clk);
        gameover = 1'b1;
        @(negedge clk);
        chk("go_tick_pulse", 32'({d, u, r, l}), 0);
        chk("go_running", 32'(running), 0);
        chk("go_dir", 32'(dir), 3);
        gameover = 1'b0;
        press(K_L, 3);
        n_pulses = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if ({d, u, r, l} != 4'b0) n_pulses++;
        end
        chk("halt_pulses", 32'(n_pulses), 0);
        chk("halt_running", 32'(running), 0);
        chk("halt_dir", 32'(dir), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
